// File: rtl/mc_reg_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mc_reg_bank
//  Purpose  : Bank of WIDTH independent CoolRunner-II macrocell registers.
//             Each bit is a D or T flop (T_MASK), with its own power-on
//             value (INIT), global set/reset value (GSR_VAL) and output
//             inversion (INVERT_OUT, applied to OUT only). Feeds the
//             ORTERM/XOR macrocell output path in simulation.
//  Option   : COOLRUNNER2_MC_DDR_EN - when defined, bits with DDR_MASK[i]=1
//             also update on the falling edge of C. When undefined, no
//             falling-edge logic exists and DDR_MASK is ignored.
//  Ports    : C        in   clock (rising edge; also falling for DDR bits)
//             CLR_B    in   asynchronous active-low reset, loads INIT
//             GSR      in   synchronous global set/reset, loads GSR_VAL
//             CE       in   [WIDTH] per-bit clock enable
//             D        in   [WIDTH] per-bit data (D mode) / toggle (T mode)
//             Q        out  [WIDTH] raw register state
//             OUT      out  [WIDTH] Q ^ INVERT_OUT
//             TOGGLED  out  [WIDTH] Q[i] changed on the bit's last active edge
//  Revision : 1.0 - initial release
// ============================================================================
module mc_reg_bank #(
  parameter int WIDTH      = 16,
  parameter     INIT       = {WIDTH{1'b0}},
  parameter     T_MASK     = {WIDTH{1'b0}},
  parameter     GSR_VAL    = {WIDTH{1'b0}},
  parameter     INVERT_OUT = {WIDTH{1'b0}},
  parameter     DDR_MASK   = {WIDTH{1'b0}}
) (
  input  logic             C,
  input  logic             CLR_B,
  input  logic             GSR,
  input  logic [WIDTH-1:0] CE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] TOGGLED
);

  // --------------------------------------------------------------------------
  // Elaboration checks
  // --------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("mc_reg_bank: WIDTH must be in 1..64");
  end
  if ($bits(INIT) != WIDTH) begin : g_bad_init
    $error("mc_reg_bank: INIT width differs from WIDTH");
  end
  if ($bits(T_MASK) != WIDTH) begin : g_bad_tmask
    $error("mc_reg_bank: T_MASK width differs from WIDTH");
  end
  if ($bits(GSR_VAL) != WIDTH) begin : g_bad_gsr
    $error("mc_reg_bank: GSR_VAL width differs from WIDTH");
  end
  if ($bits(INVERT_OUT) != WIDTH) begin : g_bad_inv
    $error("mc_reg_bank: INVERT_OUT width differs from WIDTH");
  end
  if ($bits(DDR_MASK) != WIDTH) begin : g_bad_ddr
    $error("mc_reg_bank: DDR_MASK width differs from WIDTH");
  end
`ifndef COOLRUNNER2_MC_DDR_EN
  if (DDR_MASK != 0) begin : g_ddr_ignored
    $warning("mc_reg_bank: DDR_MASK is nonzero but dual-edge support is not compiled in; ignored");
  end
`endif

  localparam logic [WIDTH-1:0] c_init  = INIT;
  localparam logic [WIDTH-1:0] c_tmask = T_MASK;
  localparam logic [WIDTH-1:0] c_gsr   = GSR_VAL;
  localparam logic [WIDTH-1:0] c_inv   = INVERT_OUT;

  // --------------------------------------------------------------------------
  // State and next-state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q_pos;    // rising-edge state register
  logic [WIDTH-1:0] r_tog_pos;  // rising-edge toggle flag register
  logic [WIDTH-1:0] w_q;        // current macrocell state
  logic [WIDTH-1:0] w_tog;      // current toggle flags
  logic [WIDTH-1:0] w_nxt;      // state after the next active edge
  logic [WIDTH-1:0] w_chg;      // bits that would change on that edge

  // Priority per bit: GSR, then CE hold, then toggle or load.
  always_comb begin
    w_nxt = (~CE & w_q) | (CE & ((c_tmask & (w_q ^ D)) | (~c_tmask & D)));
    if (GSR) begin
      w_nxt = c_gsr;
    end
    w_chg = w_nxt ^ w_q;
  end

`ifdef COOLRUNNER2_MC_DDR_EN
  // Dual-edge bits are held as the XOR of a rising-edge and a falling-edge
  // register. Each edge writes its own register so that the XOR equals the
  // new value; neither register is ever written from both edges. Non-DDR
  // bits keep their falling-edge register at zero permanently.
  localparam logic [WIDTH-1:0] c_ddr = DDR_MASK;

  logic [WIDTH-1:0] r_q_neg;
  logic [WIDTH-1:0] r_tog_neg;

  assign w_q   = r_q_pos ^ r_q_neg;
  assign w_tog = r_tog_pos ^ r_tog_neg;

  always_ff @(posedge C or negedge CLR_B) begin
    if (!CLR_B) begin
      r_q_pos   <= c_init;
      r_tog_pos <= '0;
    end else begin
      r_q_pos   <= w_nxt ^ r_q_neg;
      r_tog_pos <= w_chg ^ r_tog_neg;
    end
  end

  always_ff @(negedge C or negedge CLR_B) begin
    if (!CLR_B) begin
      r_q_neg   <= '0;
      r_tog_neg <= '0;
    end else begin
      r_q_neg   <= c_ddr & (w_nxt ^ r_q_pos);
      r_tog_neg <= c_ddr & (w_chg ^ r_tog_pos);
    end
  end
`else
  assign w_q   = r_q_pos;
  assign w_tog = r_tog_pos;

  always_ff @(posedge C or negedge CLR_B) begin
    if (!CLR_B) begin
      r_q_pos   <= c_init;
      r_tog_pos <= '0;
    end else begin
      r_q_pos   <= w_nxt;
      r_tog_pos <= w_chg;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs: inversion affects OUT only, never the stored state.
  // --------------------------------------------------------------------------
  assign Q       = w_q;
  assign OUT     = w_q ^ c_inv;
  assign TOGGLED = w_tog;

endmodule
`default_nettype wire
